mem_access_unit: RTL and testbench

MEM-stage data-memory access controller that consumes the control and data fields held in the EX→MEM pipeline register. It performs byte-lane alignment for stores, issues a request/acknowledge transaction to data memory, and sign- or zero-extends load data. It also drives a stall that freezes the EX→MEM register and all upstream stages until the access completes. Misaligned accesses and memory timeouts are reported as single-cycle fault pulses.

---
 rtl/mem_access_pkg.sv | 28 ++
 rtl/load_formatter.sv | 30 +++
 rtl/mem_access_unit.sv | 199 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared encodings, FSM states and helpers for the MEM-stage data-memory access unit.
package mem_access_pkg;

    localparam logic [1:0] W_WORD = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_BYTE = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Counter must be able to hold the value TIMEOUT itself.
    function automatic int unsigned cnt_width(input int unsigned timeout);
        return $clog2(timeout + 1);
    endfunction

    // Width code 11 behaves as a word access.
    function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] offs);
        case (width)
            W_BYTE:  return 1'b0;
            W_HALF:  return offs[0];
            default: return offs != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/load_formatter.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
module load_formatter
    import mem_access_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [1:0]  width,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
        case (width)
            W_BYTE:  result = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
            W_HALF:  result = {{16{~is_unsigned & half_sel[15]}}, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller: store lane alignment, req/ack handshake,
// load formatting, pipeline stall and misalign/timeout fault pulses.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  loadWidth,
    input  logic        loadUnsigned,
    input  logic [1:0]  storeWidth,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] LoadData,
    output logic        stall,
    output logic        misalign,
    output logic        bus_err
);

    localparam int unsigned CNT_W = cnt_width(TIMEOUT);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [3:0]         mem_be_q, mem_be_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;
    logic [31:0]        load_data_q, load_data_d;
    logic               misalign_q, misalign_d;
    logic               bus_err_q, bus_err_d;
    logic [1:0]         ld_width_q, ld_width_d;
    logic               ld_uns_q, ld_uns_d;
    logic [1:0]         ld_offs_q, ld_offs_d;
    logic               rd_only_q, rd_only_d;
    logic               rd_wr_q, rd_wr_d;

    logic               access;
    logic [1:0]         eff_width;
    logic [3:0]         req_be;
    logic [31:0]        req_wdata;
    logic               misaligned;
    logic [31:0]        fmt_data;

    load_formatter u_load_formatter (
        .rdata       (mem_rdata),
        .addr        (ld_offs_q),
        .width       (ld_width_q),
        .is_unsigned (ld_uns_q),
        .result      (fmt_data)
    );

    // Decode of the request currently presented by the EX->MEM register.
    always_comb begin
        access    = MemRead | MemWrite;
        eff_width = MemWrite ? storeWidth : loadWidth;
        case (eff_width)
            W_BYTE: begin
                req_be    = 4'b0001 << ALUResult[1:0];
                req_wdata = {4{WriteData[7:0]}};
            end
            W_HALF: begin
                req_be    = ALUResult[1] ? 4'b1100 : 4'b0011;
                req_wdata = {2{WriteData[15:0]}};
            end
            default: begin
                req_be    = 4'b1111;
                req_wdata = WriteData;
            end
        endcase
        misaligned = is_misaligned(eff_width, ALUResult[1:0]);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        load_data_d = load_data_q;
        misalign_d  = 1'b0;
        bus_err_d   = 1'b0;
        ld_width_d  = ld_width_q;
        ld_uns_d    = ld_uns_q;
        ld_offs_d   = ld_offs_q;
        rd_only_d   = rd_only_q;
        rd_wr_d     = rd_wr_q;

        case (state_q)
            S_IDLE: begin
                if (access && misaligned) begin
                    misalign_d  = 1'b1;
                    load_data_d = '0;
                    state_d     = S_DONE;
                end else if (access) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = MemWrite;
                    mem_addr_d  = {ALUResult[31:2], 2'b00};
                    mem_be_d    = req_be;
                    mem_wdata_d = MemWrite ? req_wdata : '0;
                    ld_width_d  = loadWidth;
                    ld_uns_d    = loadUnsigned;
                    ld_offs_d   = ALUResult[1:0];
                    rd_only_d   = MemRead & ~MemWrite;
                    rd_wr_d     = MemRead & MemWrite;
                    cnt_d       = '0;
                    state_d     = S_BUSY;
                end
            end
            S_BUSY: begin
                if (mem_ack || (cnt_q == CNT_W'(TIMEOUT - 1))) begin
                    if (!mem_ack) begin
                        bus_err_d   = 1'b1;
                        load_data_d = '0;
                    end else if (rd_only_q) begin
                        load_data_d = fmt_data;
                    end else if (rd_wr_q) begin
                        load_data_d = '0;
                    end
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_be_d    = '0;
                    mem_wdata_d = '0;
                    state_d     = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            load_data_q <= '0;
            misalign_q  <= 1'b0;
            bus_err_q   <= 1'b0;
            ld_width_q  <= '0;
            ld_uns_q    <= 1'b0;
            ld_offs_q   <= '0;
            rd_only_q   <= 1'b0;
            rd_wr_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            load_data_q <= load_data_d;
            misalign_q  <= misalign_d;
            bus_err_q   <= bus_err_d;
            ld_width_q  <= ld_width_d;
            ld_uns_q    <= ld_uns_d;
            ld_offs_q   <= ld_offs_d;
            rd_only_q   <= rd_only_d;
            rd_wr_q     <= rd_wr_d;
        end
    end

    // Stall must react in the same cycle the access appears.
    assign stall     = ((state_q == S_IDLE) && access) || (state_q == S_BUSY);
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
    assign LoadData  = load_data_q;
    assign misalign  = misalign_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized accesses
// against a transaction-level reference model.
module tb_mem_access_unit;

    localparam int unsigned TIMEOUT = 4;

    logic        clk;
    logic        reset;
    logic        MemRead, MemWrite, loadUnsigned;
    logic [1:0]  loadWidth, storeWidth;
    logic [31:0] ALUResult, WriteData;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, LoadData;
    logic [3:0]  mem_be;
    logic        stall, misalign, bus_err;

    int checks   = 0;
    int failures = 0;

    mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .loadWidth(loadWidth), .loadUnsigned(loadUnsigned), .storeWidth(storeWidth),
        .ALUResult(ALUResult), .WriteData(WriteData), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .LoadData(LoadData), .stall(stall), .misalign(misalign),
        .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pure arithmetic on the byte-lane rules.
    function automatic logic [3:0] m_be(input logic [1:0] w, input logic [1:0] a);
        case (w)
            2'b10:   return 4'(1 << a);
            2'b01:   return 4'(3 << (2 * a[1]));
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] w, input logic [31:0] d);
        case (w)
            2'b10:   return d[7:0] * 32'h0101_0101;
            2'b01:   return d[15:0] * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] r, input logic [1:0] a,
                                           input logic [1:0] w, input logic u);
        logic [31:0] v;
        case (w)
            2'b10: begin
                v = (r >> (8 * a)) & 32'hFF;
                if (!u && v >= 32'd128) v = v - 32'd256;
            end
            2'b01: begin
                v = (r >> (16 * a[1])) & 32'hFFFF;
                if (!u && v >= 32'h8000) v = v - 32'h10000;
            end
            default: v = r;
        endcase
        return v;
    endfunction

    function automatic logic m_mis(input logic [1:0] w, input logic [1:0] a);
        return (w == 2'b01 && a[0]) || ((w == 2'b00 || w == 2'b11) && a != 2'b00);
    endfunction

    int          obs_stall, obs_req;
    logic        obs_stable, obs_done, obs_extra, obs_mis, obs_berr, obs_req_done, obs_we;
    logic [31:0] obs_addr, obs_wdata, obs_ld;
    logic [3:0]  obs_be;
    logic        idl_mis, idl_berr, idl_req, idl_stall;
    logic [31:0] idl_ld;
    logic [31:0] exp_ld;

    // Presents one access like the pipeline would (held while stalled) and acts as memory,
    // acking in the k-th request cycle (k=0: never). Enter and leave just after a posedge.
    task automatic run_access(input logic rd, input logic wr, input logic [1:0] lw, input logic lu,
                              input logic [1:0] sw, input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] rdat, input int k, input logic stray);
        MemRead = rd; MemWrite = wr; loadWidth = lw; loadUnsigned = lu; storeWidth = sw;
        ALUResult = addr; WriteData = wd; mem_ack = 1'b0;
        obs_stall = 0; obs_req = 0; obs_stable = 1'b1; obs_done = 1'b0; obs_extra = 1'b0;
        for (int c = 0; c < 40 && !obs_done; c++) begin
            @(negedge clk);
            if (!stall) begin
                obs_done = 1'b1; obs_mis = misalign; obs_berr = bus_err;
                obs_req_done = mem_req; obs_ld = LoadData;
            end else begin
                obs_stall++;
                if (misalign || bus_err) obs_extra = 1'b1;
                if (mem_req) begin
                    obs_req++;
                    if (obs_req == 1) begin
                        obs_we = mem_we; obs_addr = mem_addr; obs_be = mem_be; obs_wdata = mem_wdata;
                    end else if (mem_we !== obs_we || mem_addr !== obs_addr ||
                                 mem_be !== obs_be || mem_wdata !== obs_wdata) begin
                        obs_stable = 1'b0;
                    end
                    mem_ack   = (obs_req == k);
                    mem_rdata = (obs_req == k) ? rdat : $urandom;
                end
                @(posedge clk); #1;
                mem_ack = 1'b0;
            end
        end
        checks++;
        if (!obs_done) begin
            failures++;
            $display("FAIL access_completes got=stall_stuck exp=done_within_40_cycles");
        end
        if (stray) begin
            mem_ack = 1'b1; mem_rdata = $urandom;
        end
        @(posedge clk); #1;
        MemRead = 1'b0; MemWrite = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        idl_mis = misalign; idl_berr = bus_err; idl_req = mem_req; idl_stall = stall; idl_ld = LoadData;
        @(posedge clk); #1;
        mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; loadWidth = 2'b00; loadUnsigned = 1'b0;
        storeWidth = 2'b00; ALUResult = '0; WriteData = '0; mem_ack = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_be, mem_wdata, LoadData, misalign, bus_err, stall} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got req=%b we=%b addr=%h be=%b wd=%h ld=%h mis=%b berr=%b stall=%b exp=all_zero",
                     mem_req, mem_we, mem_addr, mem_be, mem_wdata, LoadData, misalign, bus_err, stall);
        end
        exp_ld = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_lb_signed();
        run_access(1'b1, 1'b0, 2'b10, 1'b0, 2'b00, 32'h1003, 32'h0, 32'h80AABBCC, 1, 1'b0);
        exp_ld = 32'hFFFFFF80;
        checks++; if (obs_stall !== 2) begin failures++; $display("FAIL lb_stall got=%0d exp=2", obs_stall); end
        checks++; if (obs_addr !== 32'h1000) begin failures++; $display("FAIL lb_addr got=%h exp=00001000", obs_addr); end
        checks++; if (obs_be !== 4'b1000) begin failures++; $display("FAIL lb_be got=%b exp=1000", obs_be); end
        checks++; if (obs_we !== 1'b0) begin failures++; $display("FAIL lb_we got=%b exp=0", obs_we); end
        checks++; if (obs_ld !== exp_ld) begin failures++; $display("FAIL lb_loaddata got=%h exp=%h", obs_ld, exp_ld); end
    endtask

    task automatic test_sh_upper();
        run_access(1'b0, 1'b1, 2'b00, 1'b0, 2'b01, 32'h2002, 32'h1234BEEF, 32'h0, 1, 1'b0);
        checks++; if (obs_we !== 1'b1) begin failures++; $display("FAIL sh_we got=%b exp=1", obs_we); end
        checks++; if (obs_be !== 4'b1100) begin failures++; $display("FAIL sh_be got=%b exp=1100", obs_be); end
        checks++; if (obs_wdata !== 32'hBEEFBEEF) begin failures++; $display("FAIL sh_wdata got=%h exp=beefbeef", obs_wdata); end
        checks++; if (obs_ld !== exp_ld) begin failures++; $display("FAIL sh_loaddata_held got=%h exp=%h", obs_ld, exp_ld); end
    endtask

    task automatic test_read_write();
        run_access(1'b1, 1'b1, 2'b10, 1'b0, 2'b00, 32'h300, 32'hCAFE0001, 32'hFFFFFFFF, 1, 1'b0);
        exp_ld = '0;
        checks++; if (obs_we !== 1'b1) begin failures++; $display("FAIL rw_we got=%b exp=1", obs_we); end
        checks++; if (obs_be !== 4'b1111) begin failures++; $display("FAIL rw_be got=%b exp=1111", obs_be); end
        checks++; if (obs_ld !== 32'h0) begin failures++; $display("FAIL rw_loaddata got=%h exp=00000000", obs_ld); end
    endtask

    task automatic test_lhu_delayed();
        run_access(1'b1, 1'b0, 2'b01, 1'b1, 2'b00, 32'h10, 32'h0, 32'h0000F00D, 3, 1'b0);
        exp_ld = 32'h0000F00D;
        checks++; if (obs_stall !== 4) begin failures++; $display("FAIL lhu_stall got=%0d exp=4", obs_stall); end
        checks++; if (obs_stable !== 1'b1) begin failures++; $display("FAIL lhu_bus_stable got=%b exp=1", obs_stable); end
        checks++; if (obs_ld !== exp_ld) begin failures++; $display("FAIL lhu_loaddata got=%h exp=%h", obs_ld, exp_ld); end
    endtask

    task automatic test_misalign();
        run_access(1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 32'h1001, 32'h0, 32'h12345678, 1, 1'b0);
        exp_ld = '0;
        checks++; if (obs_req !== 0) begin failures++; $display("FAIL mis_no_req got=%0d exp=0", obs_req); end
        checks++; if (obs_stall !== 1) begin failures++; $display("FAIL mis_stall got=%0d exp=1", obs_stall); end
        checks++; if (obs_mis !== 1'b1 || obs_extra !== 1'b0) begin failures++; $display("FAIL mis_pulse got=%b/%b exp=1/0", obs_mis, obs_extra); end
        checks++; if (obs_ld !== 32'h0) begin failures++; $display("FAIL mis_loaddata got=%h exp=00000000", obs_ld); end
        idle_cycle();
        checks++; if (idl_mis !== 1'b0) begin failures++; $display("FAIL mis_single_pulse got=%b exp=0", idl_mis); end
    endtask

    task automatic test_timeout();
        run_access(1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 32'h40, 32'h0, 32'h0, 0, 1'b1);
        exp_ld = '0;
        checks++; if (obs_stall !== TIMEOUT + 1) begin failures++; $display("FAIL to_stall got=%0d exp=%0d", obs_stall, TIMEOUT + 1); end
        checks++; if (obs_req !== TIMEOUT) begin failures++; $display("FAIL to_req_cycles got=%0d exp=%0d", obs_req, TIMEOUT); end
        checks++; if (obs_berr !== 1'b1 || obs_req_done !== 1'b0) begin failures++; $display("FAIL to_berr_req got=%b/%b exp=1/0", obs_berr, obs_req_done); end
        idle_cycle();
        checks++;
        if (idl_berr !== 1'b0 || idl_req !== 1'b0 || idl_ld !== 32'h0 || idl_stall !== 1'b0) begin
            failures++;
            $display("FAIL to_stray_ack got=berr%b req%b ld%h stall%b exp=0/0/00000000/0", idl_berr, idl_req, idl_ld, idl_stall);
        end
    endtask

    task automatic test_reset_busy();
        MemRead = 1'b1; MemWrite = 1'b0; loadWidth = 2'b00; ALUResult = 32'h100;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL rb_in_busy got=%b exp=1", mem_req); end
        reset = 1'b1; MemRead = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hA5A5A5A5;
        @(negedge clk);
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_be, mem_wdata, LoadData, misalign, bus_err, stall} !== '0) begin
            failures++;
            $display("FAIL rb_outputs got req=%b be=%b addr=%h ld=%h stall=%b exp=all_zero", mem_req, mem_be, mem_addr, LoadData, stall);
        end
        @(posedge clk); #1;
        mem_ack = 1'b0;
        exp_ld = '0;
        checks++; if (LoadData !== 32'h0) begin failures++; $display("FAIL rb_late_ack got=%h exp=00000000", LoadData); end
        run_access(1'b1, 1'b0, 2'b10, 1'b1, 2'b00, 32'h101, 32'h0, 32'h1122C344, 2, 1'b0);
        exp_ld = 32'h000000C3;
        checks++; if (obs_ld !== exp_ld || obs_stall !== 3) begin failures++; $display("FAIL rb_after got=%h/%0d exp=%h/3", obs_ld, obs_stall, exp_ld); end
    endtask

    task automatic test_back_to_back();
        run_access(1'b1, 1'b0, 2'b01, 1'b0, 2'b00, 32'h22, 32'h0, 32'h9ABC0000, 1, 1'b0);
        run_access(1'b1, 1'b0, 2'b10, 1'b1, 2'b00, 32'h21, 32'h0, 32'h0000F700, 1, 1'b0);
        exp_ld = 32'h000000F7;
        checks++; if (obs_stall !== 2) begin failures++; $display("FAIL b2b_stall got=%0d exp=2", obs_stall); end
        checks++; if (obs_ld !== exp_ld) begin failures++; $display("FAIL b2b_loaddata got=%h exp=%h", obs_ld, exp_ld); end
    endtask

    task automatic test_random();
        logic rd, wr, lu, mis;
        logic [1:0] lw, sw, ew;
        logic [31:0] addr, wd, rdat;
        int k, e_stall, e_req;
        for (int i = 0; i < 60; i++) begin
            rd = 1'($urandom_range(0, 1));
            wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
            lw = 2'($urandom_range(0, 3)); sw = 2'($urandom_range(0, 3)); lu = 1'($urandom_range(0, 1));
            addr = $urandom; wd = $urandom; rdat = $urandom;
            k = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, TIMEOUT));
            ew = wr ? sw : lw;
            mis = m_mis(ew, addr[1:0]);
            run_access(rd, wr, lw, lu, sw, addr, wd, rdat, k, 1'b0);
            if (mis) begin
                e_stall = 1; e_req = 0; exp_ld = '0;
            end else if (k == 0) begin
                e_stall = TIMEOUT + 1; e_req = TIMEOUT; exp_ld = '0;
            end else begin
                e_stall = k + 1; e_req = k;
                if (rd && !wr) exp_ld = m_load(rdat, addr[1:0], lw, lu);
                else if (rd && wr) exp_ld = '0;
            end
            checks++; if (obs_stall !== e_stall) begin failures++; $display("FAIL rnd%0d_stall got=%0d exp=%0d", i, obs_stall, e_stall); end
            checks++; if (obs_req !== e_req) begin failures++; $display("FAIL rnd%0d_req got=%0d exp=%0d", i, obs_req, e_req); end
            checks++; if (obs_mis !== mis) begin failures++; $display("FAIL rnd%0d_misalign got=%b exp=%b", i, obs_mis, mis); end
            checks++; if (obs_berr !== (!mis && k == 0)) begin failures++; $display("FAIL rnd%0d_bus_err got=%b exp=%b", i, obs_berr, !mis && k == 0); end
            checks++; if (obs_ld !== exp_ld) begin failures++; $display("FAIL rnd%0d_loaddata got=%h exp=%h", i, obs_ld, exp_ld); end
            checks++; if (obs_extra !== 1'b0 || obs_req_done !== 1'b0) begin failures++; $display("FAIL rnd%0d_pulse_req got=%b/%b exp=0/0", i, obs_extra, obs_req_done); end
            if (!mis) begin
                checks++;
                if (obs_we !== wr || obs_addr !== {addr[31:2], 2'b00} || obs_be !== m_be(ew, addr[1:0]) || obs_stable !== 1'b1) begin
                    failures++;
                    $display("FAIL rnd%0d_bus got=we%b a%h be%b st%b exp=we%b a%h be%b st1", i, obs_we, obs_addr, obs_be, obs_stable,
                             wr, {addr[31:2], 2'b00}, m_be(ew, addr[1:0]));
                end
                if (wr) begin
                    checks++;
                    if (obs_wdata !== m_wdata(sw, wd)) begin failures++; $display("FAIL rnd%0d_wdata got=%h exp=%h", i, obs_wdata, m_wdata(sw, wd)); end
                end
            end
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_lb_signed();
        test_sh_upper();
        test_read_write();
        test_lhu_delayed();
        test_misalign();
        test_timeout();
        test_reset_busy();
        test_back_to_back();
        test_random();
        idle_cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=time_limit exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
